// File: rtl/score_display.sv
// Score/best-score driver for a 4-digit multiplexed common-anode 7-segment display, one shared double-dabble converter.
// Optional blink-on-crash of the score digits is built only when SCORE_DISPLAY_BLINK_EN is defined.
module score_display #(
    parameter int SCORE_W     = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               colision,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy
);

    localparam int SR_W = 8 + SCORE_W;
    localparam int CW   = $clog2(SCORE_W + 1);
    localparam int RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SHIFT_LAST = CW'(SCORE_W - 1);
    localparam logic [RW-1:0] RLAST      = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]    BLANK      = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SCORE_W-1:0] score_q, best;
    logic              colision_q;
    logic              pend_s, pend_b;
    logic              load_s, load_b, commit;
    logic              tag_best;
    logic [SR_W-1:0]   shreg;
    logic [CW-1:0]     cnt;
    logic [7:0]        score_bcd, best_bcd;
    logic [RW-1:0]     rcnt;
    logic [1:0]        sel;
    logic [3:0]        nib;
    logic              blank, blank_lo;
    logic [6:0]        seg_nxt;
    logic              crash_new;

    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        if (t[SR_W-1 -: 4] >= 4'd5) t[SR_W-1 -: 4] = t[SR_W-1 -: 4] + 4'd3;
        if (t[SR_W-5 -: 4] >= 4'd5) t[SR_W-5 -: 4] = t[SR_W-5 -: 4] + 4'd3;
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    assign busy      = (state != IDLE);
    assign crash_new = colision & ~colision_q & (score > best);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_s    = 1'b0;
        load_b    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_s) begin
                    load_s    = 1'b1;
                    state_nxt = SHIFT;
                end else if (pend_b) begin
                    load_b    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: if (cnt == SHIFT_LAST) state_nxt = DONE;
            DONE: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A change arriving in the same cycle as a load re-arms its pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q    <= '0;
            colision_q <= 1'b0;
            best       <= '0;
            pend_s     <= 1'b0;
            pend_b     <= 1'b0;
            tag_best   <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            score_bcd  <= '0;
            best_bcd   <= '0;
        end else begin
            score_q    <= score;
            colision_q <= colision;
            if (score != score_q) pend_s <= 1'b1;
            else if (load_s)      pend_s <= 1'b0;
            if (crash_new) begin
                best   <= score;
                pend_b <= 1'b1;
            end else if (load_b) begin
                pend_b <= 1'b0;
            end
            if (load_s || load_b) begin
                shreg    <= {8'd0, (load_s ? score_q : best)};
                cnt      <= '0;
                tag_best <= load_b;
            end else if (state == SHIFT) begin
                shreg <= dabble(shreg);
                cnt   <= cnt + CW'(1);
            end
            if (commit) begin
                if (tag_best) best_bcd  <= shreg[SR_W-1 -: 8];
                else          score_bcd <= shreg[SR_W-1 -: 8];
            end
        end
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] bcnt;
    logic          phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!colision) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLAST) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    assign blank_lo = phase;
`else
    // Constant low; keeps the blink period parameter referenced in the steady build.
    assign blank_lo = (BLINK_DIV < 0);
`endif

    always_comb begin
        nib   = 4'd0;
        blank = 1'b0;
        case (sel)
            2'd0: begin nib = score_bcd[3:0]; blank = blank_lo; end
            2'd1: begin nib = score_bcd[7:4]; blank = blank_lo | (score_bcd[7:4] == 4'd0); end
            2'd2: begin nib = best_bcd[3:0];  blank = 1'b0; end
            default: begin nib = best_bcd[7:4]; blank = (best_bcd[7:4] == 4'd0); end
        endcase
        seg_nxt = blank ? BLANK : seg7(nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt <= '0;
            sel  <= 2'd0;
            an   <= 4'b1111;
            seg  <= BLANK;
            dp   <= 1'b1;
        end else begin
            if (rcnt == RLAST) begin
                rcnt <= '0;
                sel  <= sel + 2'd1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
            an  <= ~(4'b0001 << sel);
            seg <= seg_nxt;
            dp  <= (sel != 2'd2);
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: reset, refresh walk, table vectors, multi-cycle corner sequences, randomized scores vs a max-of-crashes model.
module tb_score_display;

    localparam int RD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] score;
    logic       colision;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;
    int model_best;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct {
        int s;
        bit crash;
        int best;
    } vec_t;

    vec_t tbl [9];

    score_display #(.SCORE_W(6), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .score(score), .colision(colision),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte d holds {dp, seg} of digit d.
    function automatic logic [31:0] exp_disp(input int cur, input int bst);
        logic [31:0] r;
        r[7:0]   = {1'b1, segtab[cur % 10]};
        r[15:8]  = {1'b1, (cur / 10 == 0) ? 7'h7F : segtab[cur / 10]};
        r[23:16] = {1'b0, segtab[bst % 10]};
        r[31:24] = {1'b1, (bst / 10 == 0) ? 7'h7F : segtab[bst / 10]};
        return r;
    endfunction

    task automatic scan(output logic [31:0] cap);
        cap = 'x;
        for (int i = 0; i < 4 * RD + 2; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: cap[7:0]   = {dp, seg};
                4'b1101: cap[15:8]  = {dp, seg};
                4'b1011: cap[23:16] = {dp, seg};
                4'b0111: cap[31:24] = {dp, seg};
                default: ;
            endcase
        end
    endtask

    task automatic check_disp(input string name, input int cur, input int bst);
        logic [31:0] c;
        scan(c);
        check(name, c, exp_disp(cur, bst));
    endtask

    task automatic apply(input int s, input bit crash);
        score = 6'(s);
        repeat (3) @(negedge clk);
        if (crash) begin
            colision = 1'b1;
            repeat (2) @(negedge clk);
            colision = 1'b0;
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic count_busy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    initial begin
        int nb, t, bl_seen, lit_seen, d2_blank, d0_blank_after;
        logic [3:0] exp_an;
        bit changed;

        tbl[0] = '{5, 1'b1, 5};
        tbl[1] = '{4, 1'b1, 5};
        tbl[2] = '{5, 1'b1, 5};
        tbl[3] = '{50, 1'b0, 5};
        tbl[4] = '{19, 1'b1, 19};
        tbl[5] = '{63, 1'b1, 63};
        tbl[6] = '{20, 1'b1, 63};
        tbl[7] = '{0, 1'b0, 63};
        tbl[8] = '{10, 1'b0, 63};

        reset = 1'b1; score = 6'd0; colision = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an", an, 4'b1111);
        check("reset_seg", seg, 7'h7F);
        check("reset_dp", dp, 1'b1);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;

        t = 0;
        while (an !== 4'b1101 && t < 4 * RD + 4) begin
            @(negedge clk);
            t++;
        end
        check("an_sync", an, 4'b1101);
        for (int k = 1; k <= 8; k++) begin
            repeat (RD) @(negedge clk);
            exp_an = ~(4'b0001 << ((1 + k) % 4));
            check("an_walk", an, exp_an);
        end
        check_disp("disp_zero", 0, 0);

        score = 6'd37;
        count_busy(30, nb);
        check("busy_len_37", nb, 7);
        check_disp("disp_37", 37, 0);

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].s, tbl[i].crash);
            check_disp($sformatf("tbl%0d", i), tbl[i].s, tbl[i].best);
        end

        // Score changes while its own conversion is in flight.
        score = 6'd12;
        nb = 0; changed = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (nb == 2 && !changed) begin
                score = 6'd13;
                changed = 1'b1;
            end
        end
        check("busy_len_12_13", nb, 14);
        check_disp("disp_13", 13, 63);

        // Reset in the middle of a conversion.
        score = 6'd44;
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_start_44", busy, 1'b1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_an", an, 4'b1111);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_dp", dp, 1'b1);
        check("midreset_busy", busy, 1'b0);
        score = 6'd5;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check_disp("disp_after_reset", 5, 0);

        // Score change and crash on the same edge: two conversions, both land.
        score = 6'd42;
        colision = 1'b1;
        count_busy(40, nb);
        colision = 1'b0;
        check("busy_len_dual", nb, 14);
        repeat (4) @(negedge clk);
        check_disp("disp_dual", 42, 42);

        model_best = 42;
        for (int i = 0; i < 24; i++) begin
            int s, nburst;
            bit cr;
            nburst = $urandom_range(0, 3);
            for (int j = 0; j < nburst; j++) begin
                score = 6'($urandom_range(0, 63));
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            s  = $urandom_range(0, 63);
            cr = 1'($urandom_range(0, 1));
            apply(s, cr);
            if (cr && s > model_best) model_best = s;
            check_disp($sformatf("rand%0d", i), s, model_best);
        end

`ifdef SCORE_DISPLAY_BLINK_EN
        bl_seen = 0; lit_seen = 0; d2_blank = 0; d0_blank_after = 0;
        if (int'(score) > model_best) model_best = int'(score);
        colision = 1'b1;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (an == 4'b1110) begin
                if (seg == 7'h7F) bl_seen++;
                else lit_seen++;
            end
            if (an == 4'b1011 && seg == 7'h7F) d2_blank++;
        end
        colision = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && seg == 7'h7F) d0_blank_after++;
        end
        check("blink_blank_phase", bl_seen > 0, 1'b1);
        check("blink_lit_phase", lit_seen > 0, 1'b1);
        check("blink_best_lit", d2_blank, 0);
        check("blink_steady_after", d0_blank_after, 0);
        check_disp("blink_final", int'(score), model_best);
`else
        bl_seen = 0; lit_seen = 0; d2_blank = 0; d0_blank_after = 0;
        colision = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == 4'b1110 && seg == 7'h7F) d0_blank_after++;
        end
        colision = 1'b0;
        check("steady_no_blink", d0_blank_after, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
